// File: rtl/arb_pkg.sv
// Shared arbiter constants and types.
// Default requester count, index type, pointer wrap helper.
package arb_pkg;

  localparam int ARB_N_REQS = 4;
  localparam int ARB_IDX_W  =
    (ARB_N_REQS > 1) ? $clog2(ARB_N_REQS) : 1;

  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

  function automatic int arb_wrap_inc(
    input int idx,
    input int n
  );
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular picker.
// First set req bit at or after ptr, wrapping to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQS = ARB_N_REQS,
  parameter int IDX_W  =
    (N_REQS > 1) ? $clog2(N_REQS) : 1
) (
  input  logic [N_REQS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [N_REQS-1:0] pick,
  output logic [IDX_W-1:0]  pick_idx
);

  always_comb begin : search
    int         j;
    logic [IDX_W-1:0] jj;
    logic       found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = 0;
    jj       = '0;
    for (int k = 0; k < N_REQS; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQS) j = j - N_REQS;
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        found    = 1'b1;
        pick[jj] = 1'b1;
        pick_idx = jj;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter, valid/ready grant.
// Define RR_ARB_LOCK_EN to add the lock port.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQS = ARB_N_REQS,
  parameter int IDX_W  =
    (N_REQS > 1) ? $clog2(N_REQS) : 1
) (
  input  logic              clk,
  input  logic              rst_aL,
  input  logic [N_REQS-1:0] req,
`ifdef RR_ARB_LOCK_EN
  input  logic              lock,
`endif
  output logic [N_REQS-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid,
  input  logic              gnt_ready
);

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQS-1:0] pick;
  logic              hs;
  logic              load;
  logic              relock;

  assign gnt_valid = |gnt;
  assign hs        = gnt_valid & gnt_ready;
  assign load      = ~gnt_valid | hs;

`ifdef RR_ARB_LOCK_EN
  assign relock = hs & lock & (|(req & gnt));
`else
  assign relock = 1'b0;
`endif

  // picker searches from the post-handshake pointer
  always_comb begin
    ptr_nxt = ptr;
    if (hs && !relock)
      ptr_nxt = IDX_W'(arb_wrap_inc(
        int'(gnt_idx), N_REQS));
  end

  rr_pick #(
    .N_REQS (N_REQS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req      (req),
    .ptr      (ptr_nxt),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (load && !relock) begin
        gnt     <= pick;
        gnt_idx <= pick_idx;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_aL) assert ($onehot0(gnt));
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N_REQS=4).
// Compare tuples are {gnt, gnt_idx, gnt_valid}.
module tb_rr_arbiter;
  import arb_pkg::*;

  localparam int N = ARB_N_REQS;

  typedef struct packed {
    logic [N-1:0] g;
    arb_idx_t     i;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_aL = 1'b1;
  logic [N-1:0] req = '0;
  logic         gnt_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
  logic         lock = 1'b0;
`endif
  logic [N-1:0] gnt;
  arb_idx_t     gnt_idx;
  logic         gnt_valid;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  rr_arbiter dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .req       (req),
`ifdef RR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready)
  );

  function automatic arb_idx_t idx_of(
    input logic [N-1:0] g
  );
    arb_idx_t r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (g[k]) r = arb_idx_t'(k);
    return r;
  endfunction

  function automatic exp_t mk(
    input logic [N-1:0] g
  );
    exp_t e;
    e.g = g;
    e.i = idx_of(g);
    e.v = |g;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // invariants on every settled cycle
  always @(negedge clk) begin
    if (rst_aL) begin
      total++;
      if (!($onehot0(gnt) &&
            (gnt_valid == (|gnt)) &&
            (gnt_valid ? gnt[gnt_idx]
                       : (gnt_idx == '0)))) begin
        bad++;
        $display("FAIL invariant got gnt=%b idx=%0d v=%b",
                 gnt, gnt_idx, gnt_valid);
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    #1 rst_aL = 1'b0;
    #2;
    q.push_back(mk('0));
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL reset_init got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    tick();
    rst_aL = 1'b1;
    req = 4'b0100;
    q.push_back(mk(4'b0100));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL reset_pre got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    #2 rst_aL = 1'b0;
    #1;
    q.push_back(mk('0));
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    #1 rst_aL = 1'b1;
    req = 4'b1000;
    q.push_back(mk(4'b1000));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL reset_first got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    req = '0;
    gnt_ready = 1'b1;
    q.push_back(mk('0));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL reset_drain got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_rotation();
    exp_t e;
    req = 4'b1111;
    gnt_ready = 1'b1;
    q.push_back(mk(4'b0001));
    q.push_back(mk(4'b0010));
    q.push_back(mk(4'b0100));
    q.push_back(mk(4'b1000));
    q.push_back(mk(4'b0001));
    for (int k = 0; k < 5; k++) begin
      tick();
      e = q.pop_front(); total++;
      if ({gnt, gnt_idx, gnt_valid} !== e) begin
        bad++;
        $display("FAIL rot[%0d] got=%b want=%b", k,
                 {gnt, gnt_idx, gnt_valid}, e);
      end
    end
    req = '0;
    q.push_back(mk('0));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL rot_drain got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [N-1:0] stall_req [3];
    stall_req[0] = 4'b0110;
    stall_req[1] = 4'b0100;
    stall_req[2] = 4'b0001;
    gnt_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req = stall_req[k];
      q.push_back(mk(4'b0010));
      tick();
      e = q.pop_front(); total++;
      if ({gnt, gnt_idx, gnt_valid} !== e) begin
        bad++;
        $display("FAIL stall[%0d] got=%b want=%b", k,
                 {gnt, gnt_idx, gnt_valid}, e);
      end
    end
    req = '0;
    gnt_ready = 1'b1;
    q.push_back(mk('0));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL stall_release got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e;
    req = 4'b0100;
    gnt_ready = 1'b1;
    q.push_back(mk(4'b0100));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL wrap_setup got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    req = 4'b0011;
    q.push_back(mk(4'b0001));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL wrap got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    req = '0;
    q.push_back(mk('0));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL wrap_drain got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_lock();
    exp_t e;
    rst_aL = 1'b0;
    #1 rst_aL = 1'b1;
    req = 4'b0101;
    gnt_ready = 1'b1;
`ifdef RR_ARB_LOCK_EN
    lock = 1'b1;
    q.push_back(mk(4'b0001));
    q.push_back(mk(4'b0001));
    q.push_back(mk(4'b0001));
    q.push_back(mk(4'b0100));
    q.push_back(mk(4'b0001));
    for (int k = 0; k < 5; k++) begin
      if (k == 3) lock = 1'b0;
      if (k == 4) begin
        lock = 1'b1;
        req = 4'b0001;
      end
      tick();
      e = q.pop_front(); total++;
      if ({gnt, gnt_idx, gnt_valid} !== e) begin
        bad++;
        $display("FAIL lock[%0d] got=%b want=%b", k,
                 {gnt, gnt_idx, gnt_valid}, e);
      end
    end
    lock = 1'b0;
`else
    q.push_back(mk(4'b0001));
    q.push_back(mk(4'b0100));
    q.push_back(mk(4'b0001));
    q.push_back(mk(4'b0100));
    for (int k = 0; k < 4; k++) begin
      tick();
      e = q.pop_front(); total++;
      if ({gnt, gnt_idx, gnt_valid} !== e) begin
        bad++;
        $display("FAIL nolock[%0d] got=%b want=%b", k,
                 {gnt, gnt_idx, gnt_valid}, e);
      end
    end
`endif
    req = '0;
    q.push_back(mk('0));
    tick();
    e = q.pop_front(); total++;
    if ({gnt, gnt_idx, gnt_valid} !== e) begin
      bad++;
      $display("FAIL lock_drain got=%b want=%b",
               {gnt, gnt_idx, gnt_valid}, e);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_random();
    exp_t         e;
    logic [N-1:0] r;
    logic [N-1:0] m_gnt;
    logic [N-1:0] rot;
    logic         rd;
    logic         m_valid;
    logic         hs;
    int           m_ptr;
    int           m_idx;
    int           sel;
    rst_aL = 1'b0;
    #1 rst_aL = 1'b1;
    m_gnt = '0;
    m_valid = 1'b0;
    m_ptr = 0;
    m_idx = 0;
    for (int c = 0; c < 300; c++) begin
      r  = N'($urandom());
      rd = 1'($urandom_range(0, 1));
      hs = m_valid && rd;
      if (!m_valid || hs) begin
        if (hs) m_ptr = (m_idx + 1) % N;
        for (int k = 0; k < N; k++)
          rot[k] = r[(m_ptr + k) % N];
        sel = -1;
        for (int k = N - 1; k >= 0; k--)
          if (rot[k]) sel = k;
        m_gnt = '0;
        if (sel >= 0) m_gnt[(m_ptr + sel) % N] = 1'b1;
        m_valid = |m_gnt;
        m_idx = int'(idx_of(m_gnt));
      end
      req = r;
      gnt_ready = rd;
      q.push_back(mk(m_gnt));
      tick();
      e = q.pop_front(); total++;
      if ({gnt, gnt_idx, gnt_valid} !== e) begin
        bad++;
        $display("FAIL rand[%0d] got=%b want=%b", c,
                 {gnt, gnt_idx, gnt_valid}, e);
      end
    end
    req = '0;
    gnt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N_REQS, default 4: requester count; legal range 1..32.
REQ-002 Parameter IDX_W, default $clog2 of N_REQS, minimum 1: width of gnt_idx.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_aL  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQS  per-requester request bits, any combination.
REQ-006 lock  input  1  holds the grant on the current winner; present only with RR_ARB_LOCK_EN.
REQ-007 gnt  output  N_REQS  registered grant vector, one-hot or all-zeros; direct source for a downstream onehot_mux sel.
REQ-008 gnt_idx  output  IDX_W  binary index of the set bit in gnt; 0 when gnt is all-zeros.
REQ-009 gnt_valid  output  1  grant register holds a grant.
REQ-010 gnt_ready  input  1  consumer accepts the grant; handshake = gnt_valid && gnt_ready.

Function
REQ-011 Internal priority pointer ptr (IDX_W bits) names the highest-priority requester.
REQ-012 Load condition: register empty (!gnt_valid) or handshake this cycle.
REQ-013 On load: if any req bit set, gnt = one-hot of the first set bit at or after ptr, searching circularly, with gnt_valid=1; otherwise gnt=0 and gnt_valid=0.
REQ-014 Circular search wraps from index N_REQS-1 to 0.
REQ-015 Latency: req asserted in cycle t with the register empty gives gnt_valid=1 in cycle t+1.
REQ-016 Throughput: one grant per cycle while gnt_ready=1 and requests are pending.
REQ-017 Backpressure: while gnt_valid && !gnt_ready, gnt, gnt_idx and ptr hold; req changes, including withdrawal of the granted bit, are ignored.
REQ-018 On handshake, ptr takes the granted index plus 1, wrapping N_REQS-1 to 0.
REQ-019 When no handshake occurs, ptr holds.
REQ-020 Invariants every cycle: gnt is $onehot0; gnt_valid == |gnt; gnt_idx matches the set bit of gnt.
REQ-021 gnt_ready while gnt_valid=0 has no effect.
REQ-022 N_REQS=1: ptr is constant 0; gnt equals req[0] registered under the load rule.

Reset
REQ-023 rst_aL=0 clears gnt, gnt_idx, gnt_valid and ptr to 0 immediately, without waiting for a clock edge.
REQ-024 Reset mid-handshake discards the pending grant; the first load after rst_aL rises follows REQ-013 with ptr=0.

Configuration
REQ-025 Macro RR_ARB_LOCK_EN defined: lock port exists; at a handshake with lock=1, if req still has the granted bit set, the same requester is granted again and ptr does not advance; otherwise REQ-018 applies.
REQ-026 Macro RR_ARB_LOCK_EN undefined: no lock port; pure round-robin per REQ-018.

Structure
REQ-027 Shared package arb_pkg holds the default requester count constant ARB_N_REQS and the index typedef arb_idx_t.
REQ-028 Combinational circular picker lives in sub-module rr_pick; inputs req and ptr; outputs one-hot pick and its index.
REQ-029 rr_arbiter holds only the registers, the handshake logic and the lock logic.
REQ-030 An onehot0 check on gnt is an immediate assertion sampled after posedge and disabled during reset.

Verification (N_REQS=4)
REQ-031 Reset: rst_aL=0 mid-stream with gnt=0100 valid -> gnt=0000, gnt_valid=0 at once; after release, req=1000 -> gnt=1000, gnt_idx=3 one cycle later.
REQ-032 Rotation: req=1111, gnt_ready=1 held -> gnt sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 Backpressure: req=0110, gnt_ready=0 for 3 cycles, then req=0000 and gnt_ready=1 -> gnt holds 0010 for all 3 stalled cycles; gnt_valid=0 the cycle after the handshake.
REQ-034 Wrap: after a grant of 0100 is handshaken (ptr=3), req=0011 -> gnt=0001.
REQ-035 Lock (macro defined): req=0101, lock=1, gnt_ready=1 -> gnt 0001 repeats; lock drops to 0 -> next gnt=0100.
REQ-036 Same stimulus as REQ-035 with the macro undefined -> gnt alternates 0001, 0100, 0001.
